eth_phy_10g_tx_hdr_gen: RTL and testbench
=========================================

ETH_PHY_10G_TX_HDR_GEN -- requirements
Module: eth_phy_10g_tx_hdr_gen

Interface
REQ-001 Parameters: DATA_WIDTH, 64, SERDES data width; HDR_WIDTH, 2, sync header width; LFSR_SEED, 16'hACE1, nonzero LFSR reset value; RUN_TARGET, 64, consecutive-valid-header goal.
REQ-002 tx_clk  in  1  single clock; all state on rising edge.
REQ-003 tx_rst_n  in  1  reset, asynchronous assert, active-low.
REQ-004 cfg_enable  in  1  1 = generate stream, 0 = return to IDLE.
REQ-005 cfg_err_rate  in  8  invalid-header injection threshold, probability cfg_err_rate/256 per block.
REQ-006 cfg_burst_len  in  4  invalid headers per injection event; 0 treated as 1.
REQ-007 serdes_tx_data  out  DATA_WIDTH  block payload.
REQ-008 serdes_tx_hdr  out  HDR_WIDTH  sync header: 2'b01 valid, 2'b11 invalid.
REQ-009 hdr_valid_count  out  32  valid headers emitted, saturating.
REQ-010 hdr_invalid_count  out  32  invalid headers emitted, saturating.
REQ-011 run_count  out  16  current consecutive valid headers, saturating at 16'hFFFF.
REQ-012 run_hit_count  out  16  times run_count reached RUN_TARGET, saturating.

Function
REQ-013 FSM states IDLE, RUN, ERR_BURST; all outputs registered, 1-cycle latency from state/LFSR to serdes_tx_*.
REQ-014 IDLE: serdes_tx_data = 0, serdes_tx_hdr = 2'b01; counters, run_count and LFSR hold; pattern index reset to 0.
REQ-015 IDLE -> RUN when cfg_enable = 1; any state -> IDLE on the cycle after cfg_enable = 0 is sampled, aborting any burst.
REQ-016 Pattern index cycles 0..5, wrapping 5 -> 0, advancing once per emitted block in RUN or ERR_BURST: FFFFFFFFFFFFFFFF, 0000000000000000, 5555555555555555, AAAAAAAAAAAAAAAA, FEFEFEFEFEFEFEFE, 0707070707070707.
REQ-017 LFSR: 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1, advances once per cycle in RUN and ERR_BURST, holds in IDLE; reloads LFSR_SEED if it ever reaches 0.
REQ-018 In RUN, block is invalid when LFSR[7:0] < cfg_err_rate (unsigned), else valid; cfg_err_rate = 0 never injects.
REQ-019 RUN -> ERR_BURST on an invalid decision when effective burst length > 1; burst remaining counter loaded with length-1; current block counts as first invalid.
REQ-020 ERR_BURST: every block invalid, no LFSR compare; remaining counter decrements per block; at 0 -> RUN on next block.
REQ-021 Valid block: hdr_valid_count +1, run_count +1 (saturating); run_hit_count +1 exactly when the incremented run_count equals RUN_TARGET.
REQ-022 Invalid block: hdr_invalid_count +1, run_count cleared to 0.
REQ-023 Counters saturate at all-ones, never wrap; cfg changes sampled each cycle, mid-burst changes to cfg_burst_len ignored until next event.

Reset
REQ-024 tx_rst_n = 0 asynchronously forces IDLE, LFSR = LFSR_SEED, pattern index 0, burst counter 0, serdes_tx_data = 0, serdes_tx_hdr = 2'b01, all count outputs 0.
REQ-025 Reset assertion mid-burst or mid-run discards state with no residual injection after release; first block emitted no earlier than 2 cycles after release with cfg_enable = 1.

Verification
REQ-026 cfg_err_rate = 0, enable for 130 blocks -> all hdr 2'b01, hdr_invalid_count = 0, run_count = 130, run_hit_count = 1, data cycles through the 6 patterns in order.
REQ-027 cfg_err_rate = 255, cfg_burst_len = 0 -> invalid iff LFSR[7:0] != 8'hFF; invalid count matches reference LFSR model from LFSR_SEED, run_count resets at each 2'b11.
REQ-028 cfg_err_rate forcing one injection, cfg_burst_len = 4 -> exactly 4 consecutive 2'b11 blocks, hdr_invalid_count +4, run_count 0 then increments.
REQ-029 Drop cfg_enable mid-burst after 2 of 4 invalids -> IDLE next cycle, hdr 2'b01, data 0, counts frozen; re-enable -> pattern restarts at FFFF...FFFF.
REQ-030 Assert tx_rst_n = 0 asynchronously between clock edges during RUN -> outputs and counts 0, hdr 2'b01 immediately, LFSR = LFSR_SEED after release.
REQ-031 Force hdr_valid_count to 32'hFFFFFFFF, emit valid block -> count holds at all-ones.

Source files
------------

// File: rtl/eth_phy_10g_tx_hdr_gen.sv
// 10G PHY transmit test-block generator: cycles fixed payload patterns and
// emits sync headers with LFSR-driven, optionally bursty invalid-header injection.
//
// state        | meaning
// ST_IDLE      | stream off; payload 0, valid header, LFSR and counters hold
// ST_RUN       | one block per cycle; injection decided by LFSR[7:0] < cfg_err_rate
// ST_ERR_BURST | remainder of an injection burst; every block invalid
module eth_phy_10g_tx_hdr_gen #(
  parameter int          DATA_WIDTH = 64,
  parameter int          HDR_WIDTH  = 2,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1,
  parameter int          RUN_TARGET = 64
) (
  input  logic                  tx_clk,
  input  logic                  tx_rst_n,
  input  logic                  cfg_enable,
  input  logic [7:0]            cfg_err_rate,
  input  logic [3:0]            cfg_burst_len,
  output logic [DATA_WIDTH-1:0] serdes_tx_data,
  output logic [HDR_WIDTH-1:0]  serdes_tx_hdr,
  output logic [31:0]           hdr_valid_count,
  output logic [31:0]           hdr_invalid_count,
  output logic [15:0]           run_count,
  output logic [15:0]           run_hit_count
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_ERR_BURST} state_t;

  localparam logic [HDR_WIDTH-1:0] HDR_OK  = HDR_WIDTH'(2'b01);
  localparam logic [HDR_WIDTH-1:0] HDR_BAD = HDR_WIDTH'(2'b11);

  state_t                state_q, state_d;
  logic [15:0]           lfsr_q, lfsr_d;
  logic [2:0]            pat_idx_q, pat_idx_d;
  logic [3:0]            burst_rem_q, burst_rem_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [HDR_WIDTH-1:0]  hdr_q, hdr_d;
  logic [31:0]           hdr_valid_count_q, hdr_valid_count_d;
  logic [31:0]           hdr_invalid_count_q, hdr_invalid_count_d;
  logic [15:0]           run_count_q, run_count_d;
  logic [15:0]           run_hit_count_q, run_hit_count_d;

  logic       emit;
  logic       invalid;
  logic       lfsr_fb;
  logic [3:0] burst_eff;

  function automatic logic [DATA_WIDTH-1:0] pattern(input logic [2:0] idx);
    logic [7:0] b;
    case (idx)
      3'd0:    b = 8'hFF;
      3'd1:    b = 8'h00;
      3'd2:    b = 8'h55;
      3'd3:    b = 8'hAA;
      3'd4:    b = 8'hFE;
      default: b = 8'h07;
    endcase
    return {(DATA_WIDTH/8){b}};
  endfunction

  assign lfsr_fb   = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
  assign burst_eff = (cfg_burst_len == 4'd0) ? 4'd1 : cfg_burst_len;

  always_comb begin
    state_d             = state_q;
    lfsr_d              = lfsr_q;
    pat_idx_d           = pat_idx_q;
    burst_rem_d         = burst_rem_q;
    data_d              = '0;
    hdr_d               = HDR_OK;
    hdr_valid_count_d   = hdr_valid_count_q;
    hdr_invalid_count_d = hdr_invalid_count_q;
    run_count_d         = run_count_q;
    run_hit_count_d     = run_hit_count_q;
    emit                = 1'b0;
    invalid             = 1'b0;

    case (state_q)
      ST_IDLE: begin
        pat_idx_d = 3'd0;
        if (cfg_enable) state_d = ST_RUN;
      end
      ST_RUN: begin
        emit = 1'b1;
        if (lfsr_q[7:0] < cfg_err_rate) begin
          invalid = 1'b1;
          if (burst_eff > 4'd1) begin
            state_d     = ST_ERR_BURST;
            burst_rem_d = burst_eff - 4'd1;
          end
        end
      end
      ST_ERR_BURST: begin
        emit        = 1'b1;
        invalid     = 1'b1;
        burst_rem_d = burst_rem_q - 4'd1;
        if (burst_rem_q <= 4'd1) state_d = ST_RUN;
      end
      default: state_d = ST_IDLE;
    endcase

    // Disable wins over everything, including an in-flight burst.
    if (!cfg_enable) begin
      state_d     = ST_IDLE;
      burst_rem_d = 4'd0;
      pat_idx_d   = 3'd0;
      emit        = 1'b0;
    end

    if (emit) begin
      data_d    = pattern(pat_idx_q);
      hdr_d     = invalid ? HDR_BAD : HDR_OK;
      pat_idx_d = (pat_idx_q == 3'd5) ? 3'd0 : pat_idx_q + 3'd1;
      lfsr_d    = (lfsr_q == 16'd0) ? LFSR_SEED : {lfsr_q[14:0], lfsr_fb};
      if (invalid) begin
        if (~&hdr_invalid_count_q) hdr_invalid_count_d = hdr_invalid_count_q + 32'd1;
        run_count_d = 16'd0;
      end else begin
        if (~&hdr_valid_count_q) hdr_valid_count_d = hdr_valid_count_q + 32'd1;
        // Hit counts only on an actual increment, so a saturated run never re-triggers.
        if (~&run_count_q) begin
          run_count_d = run_count_q + 16'd1;
          if (run_count_d == 16'(RUN_TARGET) && ~&run_hit_count_q)
            run_hit_count_d = run_hit_count_q + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge tx_clk or negedge tx_rst_n) begin
    if (!tx_rst_n) begin
      state_q             <= ST_IDLE;
      lfsr_q              <= LFSR_SEED;
      pat_idx_q           <= 3'd0;
      burst_rem_q         <= 4'd0;
      data_q              <= '0;
      hdr_q               <= HDR_OK;
      hdr_valid_count_q   <= 32'd0;
      hdr_invalid_count_q <= 32'd0;
      run_count_q         <= 16'd0;
      run_hit_count_q     <= 16'd0;
    end else begin
      state_q             <= state_d;
      lfsr_q              <= lfsr_d;
      pat_idx_q           <= pat_idx_d;
      burst_rem_q         <= burst_rem_d;
      data_q              <= data_d;
      hdr_q               <= hdr_d;
      hdr_valid_count_q   <= hdr_valid_count_d;
      hdr_invalid_count_q <= hdr_invalid_count_d;
      run_count_q         <= run_count_d;
      run_hit_count_q     <= run_hit_count_d;
    end
  end

  assign serdes_tx_data    = data_q;
  assign serdes_tx_hdr     = hdr_q;
  assign hdr_valid_count   = hdr_valid_count_q;
  assign hdr_invalid_count = hdr_invalid_count_q;
  assign run_count         = run_count_q;
  assign run_hit_count     = run_hit_count_q;

endmodule

// File: tb/tb_eth_phy_10g_tx_hdr_gen.sv
// Scoreboard bench for eth_phy_10g_tx_hdr_gen: a block-level reference model
// predicts every cycle's outputs; a monitor pops and compares after each edge.
module tb_eth_phy_10g_tx_hdr_gen;

  logic        tx_clk = 1'b0;
  logic        tx_rst_n = 1'b0;
  logic        cfg_enable = 1'b0;
  logic [7:0]  cfg_err_rate = 8'd0;
  logic [3:0]  cfg_burst_len = 4'd0;
  logic [63:0] serdes_tx_data;
  logic [1:0]  serdes_tx_hdr;
  logic [31:0] hdr_valid_count;
  logic [31:0] hdr_invalid_count;
  logic [15:0] run_count;
  logic [15:0] run_hit_count;

  eth_phy_10g_tx_hdr_gen #(
    .DATA_WIDTH(64), .HDR_WIDTH(2), .LFSR_SEED(16'hACE1), .RUN_TARGET(64)
  ) dut (
    .tx_clk(tx_clk), .tx_rst_n(tx_rst_n), .cfg_enable(cfg_enable),
    .cfg_err_rate(cfg_err_rate), .cfg_burst_len(cfg_burst_len),
    .serdes_tx_data(serdes_tx_data), .serdes_tx_hdr(serdes_tx_hdr),
    .hdr_valid_count(hdr_valid_count), .hdr_invalid_count(hdr_invalid_count),
    .run_count(run_count), .run_hit_count(run_hit_count)
  );

  always #5 tx_clk = ~tx_clk;

  typedef struct {
    logic [63:0] data;
    logic [1:0]  hdr;
    logic [31:0] vc;
    logic [31:0] ic;
    logic [15:0] run;
    logic [15:0] hit;
  } exp_t;

  exp_t sb[$];
  bit   mon_en = 1'b0;
  int   errors = 0;
  int   checks = 0;

  logic [63:0] pats [6];
  bit          m_active;
  int          m_left;
  logic [15:0] m_lfsr;
  int          m_pat;
  logic [31:0] m_vc, m_ic;
  logic [15:0] m_run, m_hit;

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    logic fb;
    if (l == 16'd0) return 16'hACE1;
    fb = l[15] ^ l[13] ^ l[12] ^ l[10];
    return {l[14:0], fb};
  endfunction

  function automatic void model_reset();
    m_active = 0; m_left = 0; m_lfsr = 16'hACE1; m_pat = 0;
    m_vc = 0; m_ic = 0; m_run = 0; m_hit = 0;
  endfunction

  function automatic exp_t model_snapshot();
    exp_t e;
    e.data = 64'd0; e.hdr = 2'b01;
    e.vc = m_vc; e.ic = m_ic; e.run = m_run; e.hit = m_hit;
    return e;
  endfunction

  // Predicts the outputs visible after the next rising edge.
  function automatic exp_t model_step(input bit en, input logic [7:0] rate, input logic [3:0] bl);
    exp_t e;
    bit   inv;
    e = model_snapshot();
    if (!en) begin
      m_active = 0; m_left = 0; m_pat = 0;
    end else if (!m_active) begin
      m_active = 1;
    end else begin
      if (m_left > 0) begin
        inv = 1; m_left--;
      end else begin
        inv = (m_lfsr[7:0] < rate);
        if (inv) m_left = ((bl == 0) ? 1 : int'(bl)) - 1;
      end
      e.data = pats[m_pat];
      e.hdr  = inv ? 2'b11 : 2'b01;
      m_pat  = (m_pat + 1) % 6;
      m_lfsr = lfsr_next(m_lfsr);
      if (inv) begin
        if (m_ic != 32'hFFFF_FFFF) m_ic++;
        m_run = 0;
      end else begin
        if (m_vc != 32'hFFFF_FFFF) m_vc++;
        if (m_run != 16'hFFFF) begin
          m_run++;
          if (m_run == 16'd64 && m_hit != 16'hFFFF) m_hit++;
        end
      end
      e.vc = m_vc; e.ic = m_ic; e.run = m_run; e.hit = m_hit;
    end
    return e;
  endfunction

  task automatic drive(input bit en, input logic [7:0] rate, input logic [3:0] bl);
    cfg_enable = en; cfg_err_rate = rate; cfg_burst_len = bl;
    sb.push_back(model_step(en, rate, bl));
  endtask

  task automatic cycle(input bit en, input logic [7:0] rate, input logic [3:0] bl);
    @(negedge tx_clk);
    drive(en, rate, bl);
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Reset asserted between edges; outputs must clear without waiting for a clock.
  task automatic reset_mid(input bit en_after, input logic [7:0] rate, input logic [3:0] bl);
    @(negedge tx_clk);
    model_reset();
    sb.push_back(model_snapshot());
    #2 tx_rst_n = 1'b0;
    #1;
    chk("rst_async_data", serdes_tx_data, 64'd0);
    chk("rst_async_hdr", 64'(serdes_tx_hdr), 64'd1);
    chk("rst_async_vc", 64'(hdr_valid_count), 64'd0);
    chk("rst_async_ic", 64'(hdr_invalid_count), 64'd0);
    chk("rst_async_run", 64'(run_count), 64'd0);
    @(negedge tx_clk);
    tx_rst_n = 1'b1;
    drive(en_after, rate, bl);
  endtask

  // Walks until the next block would be a compare-valid RUN block, then forces one injection.
  task automatic inject_once(input logic [3:0] bl);
    @(negedge tx_clk);
    while (m_lfsr[7:0] == 8'hFF || m_left != 0) begin
      drive(1'b1, 8'd0, bl);
      @(negedge tx_clk);
    end
    drive(1'b1, m_lfsr[7:0] + 8'd1, bl);
  endtask

  initial begin : monitor
    exp_t e;
    int   shown = 0;
    forever begin
      @(posedge tx_clk);
      #1;
      if (mon_en) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_underflow: no expected entry at %0t", $time);
        end else begin
          e = sb.pop_front();
          if (serdes_tx_data !== e.data || serdes_tx_hdr !== e.hdr || hdr_valid_count !== e.vc ||
              hdr_invalid_count !== e.ic || run_count !== e.run || run_hit_count !== e.hit) begin
            errors++;
            if (shown < 30) begin
              shown++;
              $display("FAIL block t=%0t: got data=%h hdr=%b vc=%0d ic=%0d run=%0d hit=%0d expected data=%h hdr=%b vc=%0d ic=%0d run=%0d hit=%0d",
                       $time, serdes_tx_data, serdes_tx_hdr, hdr_valid_count, hdr_invalid_count,
                       run_count, run_hit_count, e.data, e.hdr, e.vc, e.ic, e.run, e.hit);
            end
          end
        end
      end
    end
  end

  initial begin : stimulus
    logic [31:0] ic_before;
    pats[0] = 64'hFFFF_FFFF_FFFF_FFFF; pats[1] = 64'h0000_0000_0000_0000;
    pats[2] = 64'h5555_5555_5555_5555; pats[3] = 64'hAAAA_AAAA_AAAA_AAAA;
    pats[4] = 64'hFEFE_FEFE_FEFE_FEFE; pats[5] = 64'h0707_0707_0707_0707;
    model_reset();

    // Reset state, then 130 clean blocks.
    @(negedge tx_clk);
    sb.push_back(model_snapshot());
    mon_en = 1'b1;
    @(negedge tx_clk);
    tx_rst_n = 1'b1;
    drive(1'b1, 8'd0, 4'd0);
    repeat (130) cycle(1'b1, 8'd0, 4'd0);
    @(negedge tx_clk);
    chk("clean_run_count", 64'(run_count), 64'd130);
    chk("clean_hit_count", 64'(run_hit_count), 64'd1);
    chk("clean_invalid", 64'(hdr_invalid_count), 64'd0);
    chk("clean_valid", 64'(hdr_valid_count), 64'd130);
    drive(1'b0, 8'd0, 4'd0);

    // Maximum rate from a fresh seed: invalid unless LFSR low byte is FF.
    reset_mid(1'b1, 8'd255, 4'd0);
    repeat (200) cycle(1'b1, 8'd255, 4'd0);
    @(negedge tx_clk);
    chk("rate255_invalid", 64'(hdr_invalid_count), 64'(m_ic));
    drive(1'b0, 8'd0, 4'd0);

    // Single injection with a 4-block burst.
    repeat (6) cycle(1'b1, 8'd0, 4'd4);
    ic_before = m_ic;
    inject_once(4'd4);
    repeat (8) cycle(1'b1, 8'd0, 4'd4);
    @(negedge tx_clk);
    chk("burst4_invalid_delta", 64'(hdr_invalid_count), 64'(ic_before + 32'd4));
    chk("burst4_run_after", 64'(run_count), 64'd8 - 64'd3);
    drive(1'b1, 8'd0, 4'd4);

    // Disable after two invalids of a four-block burst, then re-enable.
    inject_once(4'd4);
    cycle(1'b1, 8'd0, 4'd4);
    repeat (4) cycle(1'b0, 8'd0, 4'd4);
    @(negedge tx_clk);
    chk("abort_hdr", 64'(serdes_tx_hdr), 64'd1);
    chk("abort_data", serdes_tx_data, 64'd0);
    drive(1'b1, 8'd0, 4'd0);
    repeat (8) cycle(1'b1, 8'd0, 4'd0);

    // Asynchronous reset mid-run.
    repeat (10) cycle(1'b1, 8'd0, 4'd0);
    reset_mid(1'b1, 8'd0, 4'd0);
    repeat (5) cycle(1'b1, 8'd0, 4'd0);

    // Valid counter saturation.
    @(negedge tx_clk);
    m_vc = 32'hFFFF_FFFF;
    force dut.hdr_valid_count_q = 32'hFFFF_FFFF;
    #1 release dut.hdr_valid_count_q;
    drive(1'b1, 8'd0, 4'd0);
    repeat (3) cycle(1'b1, 8'd0, 4'd0);
    @(negedge tx_clk);
    chk("valid_saturate", 64'(hdr_valid_count), 64'hFFFF_FFFF);
    drive(1'b1, 8'd0, 4'd0);

    // Randomized configuration, including mid-burst length changes and enable drops.
    repeat (1500) begin
      bit         en;
      logic [7:0] rate;
      logic [3:0] bl;
      en   = ($urandom_range(0, 31) != 0);
      rate = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 40));
      bl   = 4'($urandom_range(0, 15));
      cycle(en, rate, bl);
    end

    @(negedge tx_clk);
    drive(1'b0, 8'd0, 4'd0);
    @(posedge tx_clk);
    #2;
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
